// File: rtl/bram_host_port.sv
// Host-side byte sequencer for the bram byte port.
//
// Write path: accepts a valid/ready byte stream (s_*) and issues one byte write per accepted
// byte into a bram line via host_input/offset/line_read_from_host. A byte sits in a one-entry
// pending register until chunk_busy allows the strobe.
// Read path: walks the same byte port, waits RD_LAT cycles for bram_to_host, and presents each
// byte on a valid/ready stream (m_*).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start_write/read     one-cycle commands, honoured only when idle (write wins)
//   start_byte, len      first byte index and byte count, sampled with the command
//   s_data/valid/ready   host write stream
//   m_data/valid/ready   host readback stream
//   chunk_busy           stalls byte write strobes
//   host_input, offset   byte and MSB bit index (8*idx+7) presented to bram
//   line_read_from_host  byte write strobe
//   bram_to_host         byte read back from bram at offset
//   busy, done           activity flag and one-cycle completion pulse
module bram_host_port #(
  parameter int unsigned num_bits = 512,
  parameter int unsigned RD_LAT   = 1,
  localparam int unsigned NB = num_bits / 8,
  localparam int unsigned IW = $clog2(NB),
  localparam int unsigned OW = $clog2(num_bits)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_write,
  input  logic          start_read,
  input  logic [IW-1:0] start_byte,
  input  logic [IW:0]   len,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          chunk_busy,
  output logic [7:0]    host_input,
  output logic [OW-1:0] offset,
  output logic          line_read_from_host,
  input  logic [7:0]    bram_to_host,
  output logic          busy,
  output logic          done
);

  // Latency counter only needs to reach RD_LAT-1.
  localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StWr, StRdAddr, StRdWait, StRdOut} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   rem_q, rem_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] pend_idx_q, pend_idx_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic [7:0]    m_data_q, m_data_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          done_q, done_d;

  logic rem_zero;
  logic wr_hs;

  assign rem_zero = (rem_q == '0);
  assign wr_hs    = s_valid && s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      m_data_q    <= '0;
      lat_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pend_data_q <= pend_data_d;
      m_data_q    <= m_data_d;
      lat_q       <= lat_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    pend_data_d = pend_data_q;
    m_data_d    = m_data_q;
    lat_d       = lat_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_write || start_read) begin
          idx_d = start_byte;
          rem_d = len;
          if (len == '0) begin
            // Empty transfer: acknowledge without leaving idle.
            done_d = 1'b1;
          end else if (start_write) begin
            state_d = StWr;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      StWr: begin
        if (wr_hs) begin
          pend_d      = 1'b1;
          pend_data_d = s_data;
          pend_idx_d  = idx_q;
          idx_d       = idx_q + 1'b1;
          rem_d       = rem_q - 1'b1;
        end else if (line_read_from_host) begin
          pend_d = 1'b0;
        end
        // No handshake is possible once rem is zero, so the strobe drains the last byte.
        if (rem_zero && (!pend_q || line_read_from_host)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRdAddr: begin
        lat_d = '0;
        if (RD_LAT == 0) begin
          m_data_d = bram_to_host;
          state_d  = StRdOut;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (lat_q == LW'(RD_LAT - 1)) begin
          m_data_d = bram_to_host;
          state_d  = StRdOut;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRdOut: begin
        if (m_ready) begin
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (IW+1)'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready             = 1'b0;
    line_read_from_host = 1'b0;
    m_valid             = 1'b0;
    offset              = '0;
    unique case (state_q)
      StWr: begin
        // A byte may be taken while the pending one drains in the same cycle.
        s_ready             = !rem_zero && (!pend_q || !chunk_busy);
        line_read_from_host = pend_q && !chunk_busy;
        offset              = {pend_idx_q, 3'b111};
      end
      StRdAddr, StRdWait: offset = {idx_q, 3'b111};
      StRdOut: begin
        m_valid = 1'b1;
        offset  = {idx_q, 3'b111};
      end
      default: ;
    endcase
  end

  assign host_input = pend_data_q;
  assign m_data     = m_data_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_bram_host_port.sv
module tb_bram_host_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_write, start_read;
  logic [5:0] start_byte;
  logic [6:0] len;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_ready;
  logic       chunk_busy;
  logic [7:0] host_input;
  logic [8:0] offset;
  logic       line_read_from_host;
  logic [7:0] bram_to_host;
  logic       busy, done;

  always #5 clk = ~clk;

  bram_host_port #(
    .num_bits(512),
    .RD_LAT  (1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_write        (start_write),
    .start_read         (start_read),
    .start_byte         (start_byte),
    .len                (len),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .chunk_busy         (chunk_busy),
    .host_input         (host_input),
    .offset             (offset),
    .line_read_from_host(line_read_from_host),
    .bram_to_host       (bram_to_host),
    .busy               (busy),
    .done               (done)
  );

  // Behavioural bram byte port, one cycle read latency.
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (line_read_from_host) mem[offset[8:3]] <= host_input;
    bram_to_host <= mem[offset[8:3]];
  end

  int checks = 0;
  int passes = 0;

  int tr_str [512];
  int tr_off [512];
  int tr_hi  [512];
  int tr_sr  [512];
  int tr_mv  [512];
  int tr_md  [512];
  int tr_busy[512];
  int tr_done[512];
  int str_off[$];
  int str_dat[$];
  int str_cyc[$];
  int rd_dat[$];
  int rd_cyc[$];
  int done_cyc;
  int stall_cyc;
  logic [7:0] wr_bytes [64];

  task automatic log_cycle(input int k);
    if (k < 0 || k >= 512) return;
    tr_str[k]  = int'(line_read_from_host);
    tr_off[k]  = int'(offset);
    tr_hi[k]   = int'(host_input);
    tr_sr[k]   = int'(s_ready);
    tr_mv[k]   = int'(m_valid);
    tr_md[k]   = int'(m_data);
    tr_busy[k] = int'(busy);
    tr_done[k] = int'(done);
    if (line_read_from_host) begin
      str_off.push_back(int'(offset));
      str_dat.push_back(int'(host_input));
      str_cyc.push_back(k);
    end
  endtask

  task automatic clear_logs();
    str_off.delete();
    str_dat.delete();
    str_cyc.delete();
    rd_dat.delete();
    rd_cyc.delete();
    done_cyc  = -1;
    stall_cyc = -1;
  endtask

  // Cycle 0 carries the start command; chunk_busy is held for 3 cycles after byte stall_byte.
  task automatic run_write(input int sb, input int n, input int stall_byte);
    int sent;
    sent = 0;
    clear_logs();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start_write = (k == 0);
      start_byte  = 6'(sb);
      len         = 7'(n);
      s_valid     = (k > 0) && (sent < n);
      s_data      = (sent < n) ? wr_bytes[sent] : 8'h00;
      chunk_busy  = (stall_cyc >= 0) && (k > stall_cyc) && (k <= stall_cyc + 3);
      #1;
      log_cycle(k);
      if (s_valid && s_ready) begin
        if (sent == stall_byte) stall_cyc = k;
        sent++;
      end
      if (done && k > 0) begin
        done_cyc = k;
        break;
      end
    end
    start_write = 1'b0;
    s_valid     = 1'b0;
    chunk_busy  = 1'b0;
  endtask

  // bp_byte: hold m_ready low 5 cycles once that byte is valid. pulse_k: extra start_read
  // (start 40, len 5) at that cycle. abort_byte: return with that byte valid and unaccepted.
  task automatic run_read(input int sb, input int n, input int bp_byte, input int pulse_k,
                          input int abort_byte);
    int rcv;
    int bp_start;
    rcv      = 0;
    bp_start = -1;
    clear_logs();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start_read = (k == 0) || (k == pulse_k);
      start_byte = (k == 0) ? 6'(sb) : 6'd40;
      len        = (k == 0) ? 7'(n) : 7'd5;
      if (abort_byte >= 0 && m_valid && rcv == abort_byte) begin
        m_ready = 1'b0;
        break;
      end
      if (m_valid && rcv == bp_byte && bp_start < 0) bp_start = k;
      m_ready = !(bp_start >= 0 && k < bp_start + 5);
      #1;
      log_cycle(k);
      if (m_valid && m_ready) begin
        rd_dat.push_back(int'(m_data));
        rd_cyc.push_back(k);
        rcv++;
      end
      if (done && k > 0) begin
        done_cyc = k;
        break;
      end
    end
    start_read = 1'b0;
    m_ready    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passes++;
    checks++; if (line_read_from_host !== 1'b0) $display("FAIL reset_strobe: got %b want 0", line_read_from_host); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (host_input !== 8'h00) $display("FAIL reset_host_input: got %h want 00", host_input); else passes++;
    checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h want 00", m_data); else passes++;
    checks++; if (offset !== 9'd0) $display("FAIL reset_offset: got %0d want 0", offset); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_write();
    for (int i = 0; i < 64; i++) wr_bytes[i] = 8'(i);
    run_write(0, 64, -1);
    checks++; if (str_off.size() != 64) $display("FAIL fw_strobe_count: got %0d want 64", str_off.size()); else passes++;
    for (int i = 0; i < 64 && i < str_off.size(); i++) begin
      checks++; if (str_off[i] != 8*i+7) $display("FAIL fw_offset[%0d]: got %0d want %0d", i, str_off[i], 8*i+7); else passes++;
      checks++; if (str_dat[i] != i) $display("FAIL fw_data[%0d]: got %0d want %0d", i, str_dat[i], i); else passes++;
      checks++; if (str_cyc[i] != i+2) $display("FAIL fw_cycle[%0d]: got %0d want %0d", i, str_cyc[i], i+2); else passes++;
    end
    checks++; if (done_cyc != 66) $display("FAIL fw_done_cycle: got %0d want 66", done_cyc); else passes++;
    checks++; if (tr_busy[1] != 1) $display("FAIL fw_busy_rise: got %0d want 1", tr_busy[1]); else passes++;
    checks++; if (tr_busy[66] != 0) $display("FAIL fw_busy_fall: got %0d want 0", tr_busy[66]); else passes++;
  endtask

  task automatic test_full_read();
    run_read(0, 64, -1, -1, -1);
    checks++; if (rd_dat.size() != 64) $display("FAIL fr_count: got %0d want 64", rd_dat.size()); else passes++;
    for (int i = 0; i < 64 && i < rd_dat.size(); i++) begin
      checks++; if (rd_dat[i] != i) $display("FAIL fr_data[%0d]: got %0d want %0d", i, rd_dat[i], i); else passes++;
      checks++; if (rd_cyc[i] != 3+3*i) $display("FAIL fr_cycle[%0d]: got %0d want %0d", i, rd_cyc[i], 3+3*i); else passes++;
    end
    checks++; if (tr_mv[2] != 0) $display("FAIL fr_early_valid: got %0d want 0", tr_mv[2]); else passes++;
    checks++; if (done_cyc != 193) $display("FAIL fr_done_cycle: got %0d want 193", done_cyc); else passes++;
    checks++; if (str_off.size() != 0) $display("FAIL fr_no_strobe: got %0d want 0", str_off.size()); else passes++;
  endtask

  task automatic test_backpressure();
    int exp_cyc [8];
    exp_cyc = '{3, 6, 9, 12, 15, 23, 26, 29};
    run_read(0, 8, 5, -1, -1);
    checks++; if (rd_dat.size() != 8) $display("FAIL bp_count: got %0d want 8", rd_dat.size()); else passes++;
    for (int i = 0; i < 8 && i < rd_dat.size(); i++) begin
      checks++; if (rd_dat[i] != i) $display("FAIL bp_data[%0d]: got %0d want %0d", i, rd_dat[i], i); else passes++;
      checks++; if (rd_cyc[i] != exp_cyc[i]) $display("FAIL bp_cycle[%0d]: got %0d want %0d", i, rd_cyc[i], exp_cyc[i]); else passes++;
    end
    for (int k = 18; k <= 22; k++) begin
      checks++; if (tr_mv[k] != 1) $display("FAIL bp_valid@%0d: got %0d want 1", k, tr_mv[k]); else passes++;
      checks++; if (tr_md[k] != 5) $display("FAIL bp_data_hold@%0d: got %0d want 5", k, tr_md[k]); else passes++;
    end
    for (int k = 16; k <= 23; k++) begin
      checks++; if (tr_off[k] != 47) $display("FAIL bp_offset_hold@%0d: got %0d want 47", k, tr_off[k]); else passes++;
    end
    checks++; if (tr_off[24] != 55) $display("FAIL bp_next_addr: got %0d want 55", tr_off[24]); else passes++;
    checks++; if (done_cyc != 30) $display("FAIL bp_done_cycle: got %0d want 30", done_cyc); else passes++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) wr_bytes[i] = 8'(8'h80 + i);
    run_write(0, 16, 10);
    checks++; if (stall_cyc != 11) $display("FAIL st_hs_cycle: got %0d want 11", stall_cyc); else passes++;
    for (int k = 12; k <= 14; k++) begin
      checks++; if (tr_str[k] != 0) $display("FAIL st_no_strobe@%0d: got %0d want 0", k, tr_str[k]); else passes++;
      checks++; if (tr_off[k] != 87) $display("FAIL st_offset_hold@%0d: got %0d want 87", k, tr_off[k]); else passes++;
      checks++; if (tr_hi[k] != 'h8A) $display("FAIL st_data_hold@%0d: got %0h want 8a", k, tr_hi[k]); else passes++;
      checks++; if (tr_sr[k] != 0) $display("FAIL st_s_ready@%0d: got %0d want 0", k, tr_sr[k]); else passes++;
    end
    checks++; if (tr_str[15] != 1 || tr_off[15] != 87) $display("FAIL st_release: got strobe %0d offset %0d want 1 87", tr_str[15], tr_off[15]); else passes++;
    checks++; if (str_off.size() != 16) $display("FAIL st_strobe_count: got %0d want 16", str_off.size()); else passes++;
    for (int i = 0; i < 16 && i < str_off.size(); i++) begin
      checks++; if (str_off[i] != 8*i+7 || str_dat[i] != 'h80+i) $display("FAIL st_byte[%0d]: got %0d/%0h want %0d/%0h", i, str_off[i], str_dat[i], 8*i+7, 'h80+i); else passes++;
    end
    checks++; if (done_cyc != 21) $display("FAIL st_done_cycle: got %0d want 21", done_cyc); else passes++;
  endtask

  task automatic test_wrap();
    int exp_off [4];
    int exp_dat [4];
    exp_off = '{503, 511, 7, 15};
    exp_dat = '{'hAA, 'hBB, 'hCC, 'hDD};
    wr_bytes[0] = 8'hAA; wr_bytes[1] = 8'hBB; wr_bytes[2] = 8'hCC; wr_bytes[3] = 8'hDD;
    run_write(62, 4, -1);
    checks++; if (str_off.size() != 4) $display("FAIL wr_strobe_count: got %0d want 4", str_off.size()); else passes++;
    for (int i = 0; i < 4 && i < str_off.size(); i++) begin
      checks++; if (str_off[i] != exp_off[i]) $display("FAIL wr_offset[%0d]: got %0d want %0d", i, str_off[i], exp_off[i]); else passes++;
    end
    checks++; if (done_cyc != 6) $display("FAIL wr_done_cycle: got %0d want 6", done_cyc); else passes++;
    run_read(62, 4, -1, -1, -1);
    checks++; if (rd_dat.size() != 4) $display("FAIL wr_rd_count: got %0d want 4", rd_dat.size()); else passes++;
    for (int i = 0; i < 4 && i < rd_dat.size(); i++) begin
      checks++; if (rd_dat[i] != exp_dat[i]) $display("FAIL wr_rd_data[%0d]: got %0h want %0h", i, rd_dat[i], exp_dat[i]); else passes++;
    end
  endtask

  task automatic test_reset_midread();
    run_read(0, 64, -1, -1, 10);
    checks++; if (m_valid !== 1'b1 || offset !== 9'd87) $display("FAIL rr_at_byte10: got valid %b offset %0d want 1 87", m_valid, offset); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rr_busy: got %b want 0", busy); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rr_m_valid: got %b want 0", m_valid); else passes++;
    checks++; if (m_data !== 8'h00) $display("FAIL rr_m_data: got %h want 00", m_data); else passes++;
    checks++; if (offset !== 9'd0) $display("FAIL rr_offset: got %0d want 0", offset); else passes++;
    checks++; if (done !== 1'b0 || s_ready !== 1'b0 || line_read_from_host !== 1'b0) $display("FAIL rr_ctrl: got done %b s_ready %b strobe %b want 0 0 0", done, s_ready, line_read_from_host); else passes++;
    checks++; if (host_input !== 8'h00) $display("FAIL rr_host_input: got %h want 00", host_input); else passes++;
    @(negedge clk);
    rst = 1'b0;
    run_read(10, 2, -1, -1, -1);
    checks++; if (rd_dat.size() != 2) $display("FAIL rr_after_count: got %0d want 2", rd_dat.size()); else passes++;
    if (rd_dat.size() == 2) begin
      checks++; if (rd_dat[0] != 'h8A || rd_dat[1] != 'h8B) $display("FAIL rr_after_data: got %0h %0h want 8a 8b", rd_dat[0], rd_dat[1]); else passes++;
    end
    checks++; if (done_cyc != 7) $display("FAIL rr_after_done: got %0d want 7", done_cyc); else passes++;
  endtask

  task automatic test_len_zero();
    for (int pass = 0; pass < 2; pass++) begin
      int n_str;
      int n_mv;
      int dn [4];
      int bz [4];
      n_str = 0;
      n_mv  = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start_write = (k == 0) && (pass == 0);
        start_read  = (k == 0) && (pass == 1);
        start_byte  = 6'd5;
        len         = 7'd0;
        s_valid     = 1'b1;
        s_data      = 8'h55;
        m_ready     = 1'b1;
        #1;
        dn[k] = int'(done);
        bz[k] = int'(busy);
        if (line_read_from_host) n_str++;
        if (m_valid) n_mv++;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      checks++; if (dn[1] != 1 || dn[0] != 0 || dn[2] != 0) $display("FAIL lz%0d_done: got %0d%0d%0d want 010", pass, dn[0], dn[1], dn[2]); else passes++;
      checks++; if (bz[1] != 0 || bz[2] != 0) $display("FAIL lz%0d_busy: got %0d%0d want 00", pass, bz[1], bz[2]); else passes++;
      checks++; if (n_str != 0 || n_mv != 0) $display("FAIL lz%0d_activity: got strobes %0d valids %0d want 0 0", pass, n_str, n_mv); else passes++;
    end
  endtask

  task automatic test_start_while_busy();
    int extra;
    run_read(0, 2, -1, 2, -1);
    checks++; if (rd_dat.size() != 2) $display("FAIL sb_count: got %0d want 2", rd_dat.size()); else passes++;
    if (rd_dat.size() == 2) begin
      checks++; if (rd_dat[0] != 'hCC || rd_dat[1] != 'hDD) $display("FAIL sb_data: got %0h %0h want cc dd", rd_dat[0], rd_dat[1]); else passes++;
      checks++; if (rd_cyc[0] != 3 || rd_cyc[1] != 6) $display("FAIL sb_cycles: got %0d %0d want 3 6", rd_cyc[0], rd_cyc[1]); else passes++;
    end
    checks++; if (done_cyc != 7) $display("FAIL sb_done_cycle: got %0d want 7", done_cyc); else passes++;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (busy || m_valid) extra++;
    end
    checks++; if (extra != 0) $display("FAIL sb_ignored: got %0d busy cycles want 0", extra); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start_write = 1'b0;
    start_read  = 1'b0;
    start_byte  = '0;
    len         = '0;
    s_data      = '0;
    s_valid     = 1'b0;
    m_ready     = 1'b0;
    chunk_busy  = 1'b0;
    test_reset();
    test_full_write();
    test_full_read();
    test_backpressure();
    test_stall();
    test_wrap();
    test_reset_midread();
    test_len_zero();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bram_host_port.md
# bram_host_port

Host-side byte sequencer for the local-memory `bram` byte port. Accepts a valid/ready byte stream from the host and issues byte writes (`host_input`/`offset`/`line_read_from_host`) into one `bram` line. Also walks the same port in reverse, reading `bram_to_host` and emitting a valid/ready byte stream back to the host. It sits between the host interface and the `bram` instance, opposite the chunk path.

## Interface
- `num_bits`, 512: `bram` line width; NB = num_bits/8 bytes; IW = $clog2(NB); OW = $clog2(num_bits).
- `RD_LAT`, 1: cycles from `offset` change to valid `bram_to_host`; must be ≥0.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start_write`  in  1  one-cycle command, honoured only in IDLE.
- `start_read`  in  1  one-cycle command, honoured only in IDLE; `start_write` wins if both are high.
- `start_byte`  in  IW  first byte index, sampled with the start command.
- `len`  in  IW+1  byte count, sampled with the start command; 0 = no transfer.
- `s_data`  in  8  host write byte.
- `s_valid`  in  1  host write byte valid.
- `s_ready`  out  1  block accepts the write byte.
- `m_data`  out  8  readback byte.
- `m_valid`  out  1  readback byte valid.
- `m_ready`  in  1  host accepts the readback byte.
- `chunk_busy`  in  1  a chunk write into `bram` is in progress; byte writes must stall.
- `host_input`  out  8  byte to `bram`.
- `offset`  out  OW  MSB bit index of the addressed byte: 8·idx+7.
- `line_read_from_host`  out  1  byte write strobe to `bram`.
- `bram_to_host`  in  8  byte read from `bram` at `offset`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WR, RD_ADDR, RD_WAIT, RD_OUT.
- The index counter `idx` (IW bits) wraps modulo NB. `start_byte`+`len` > NB continues at byte 0; no error is raised.
- A start command with `len`=0 gives a `done` pulse in the next cycle and issues no strobe or stream beat. The state stays IDLE.
- WR:
  - `s_ready` = (`remaining`>0) && (!`pend` || !`chunk_busy`).
  - A handshake loads a pending register with the byte and its `idx`, sets `pend`, increments `idx` and decrements `remaining`.
  - `line_read_from_host` = `pend` && !`chunk_busy`. A strobe clears `pend` unless a new byte is accepted in the same cycle.
  - `host_input` and `offset` come from the pending register and are held stable while `pend` is high.
  - When `remaining`=0 and `pend` clears: raise `done` for one cycle and go to IDLE.
- RD_ADDR: drive `offset` = 8·`idx`+7.
  - If RD_LAT=0, capture `bram_to_host` into `m_data` at this edge and go to RD_OUT.
  - Otherwise go to RD_WAIT.
- RD_WAIT: count RD_LAT cycles with `offset` held, capture on the last cycle, then go to RD_OUT.
- RD_OUT: `m_valid`=1 and `m_data` stays stable until `m_ready`. On handshake, increment `idx` and decrement `remaining`.
  - If bytes remain, go to RD_ADDR.
  - Otherwise pulse `done` and go to IDLE.
- `chunk_busy` is ignored during reads.
- `line_read_from_host` is never asserted outside WR.
- Start commands while `busy` are ignored.

## Timing
- Reset values: `s_ready`, `m_valid`, `line_read_from_host`, `busy` and `done` = 0; `host_input`, `m_data` and `offset` = 0. Internal `pend` and all counters = 0.
- Reset mid-operation takes effect immediately. Any pending byte is discarded with no strobe and no `done`.
- Write throughput is 1 byte/cycle with `s_valid`=1 and `chunk_busy`=0.
  - Handshake at cycle t gives a strobe at t+1.
  - `done` comes in the cycle after the final strobe.
- Read throughput is RD_LAT+2 cycles/byte with `m_ready`=1.
  - First `m_valid` at start+RD_LAT+2.
  - `done` comes in the cycle after the final handshake.
- `busy` rises the cycle after the start command and falls together with the `done` pulse.

## Test plan
- Full-line write: `start_byte`=0, `len`=64, stream bytes 0x00..0x3F with `s_valid` held high. Required: 64 consecutive strobes with offsets 7,15,…,511, `host_input` matching the stream, and `done` one cycle after offset 511.
- Full-line read: using a behavioural `bram` model (RD_LAT=1) preloaded by the previous test, `len`=64, `m_ready`=1. Required: `m_data` = 0x00..0x3F in order, one byte every 3 cycles, and `done` after byte 0x3F.
- Wrap: `start_byte`=62, `len`=4, write 0xAA,0xBB,0xCC,0xDD. Required: offsets 503,511,7,15, then a readback returns the same four bytes.
- Stall: raise `chunk_busy` for 3 cycles while writing byte 10. Required:
  - `line_read_from_host`=0 during those cycles, with `host_input`/`offset` held;
  - `s_ready`=0 once `pend` is set;
  - byte 10 is strobed once in the first cycle after `chunk_busy` falls, with no loss or duplication.
- Backpressure: hold `m_ready` low for 5 cycles at byte 5. Required: `m_valid`=1, with `m_data` and `offset` stable, and byte 6 not addressed until the handshake.
- Reset and edge cases:
  - Assert `rst` mid-read at byte 10. Required: all outputs at reset values immediately, and a following `start_read` works.
  - Issue `len`=0. Required: a `done` pulse with no strobe and no `m_valid`.
  - Pulse `start_read` while busy. Required: it is ignored.
